sparc_ifu_starv_pick: RTL and testbench

- Four-thread issue picker for the IFU switch stage, built around the per-thread 5-bit starvation counters (limit asserts at count 24).
- Drives each counter's active-low clear and consumes each counter's limit output.
- Default policy is round-robin over ready threads. Any ready thread whose counter has hit its limit takes priority over the rotation.
- Keeps a saturating count of starvation-override picks for perf monitoring.

---
 rtl/sparc_ifu_starv_pick.sv | 86 ++++++++
 tb/tb_sparc_ifu_starv_pick.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sparc_ifu_starv_pick.sv
// Four-thread issue picker for the IFU switch stage: round-robin over ready
// threads, with threads whose starvation counter hit its limit taking priority.
module sparc_ifu_starv_pick (
  input  logic       clk,
  input  logic       reset,
  input  logic       se,
  input  logic       si,
  output logic       so,
  input  logic [3:0] thr_rdy,
  input  logic       swl_stall,
  input  logic [3:0] starv_limit,
  input  logic       clr_ovr_cnt,
  output logic [3:0] rst_ctr_l,
  output logic [3:0] pick_oh,
  output logic       pick_vld,
  output logic       pick_ovr,
  output logic [7:0] ovr_cnt
);

  // Handshake: pick_vld qualifies pick_oh and pick_ovr for exactly one cycle.
  // There is no back-pressure; the consumer must take the pick when valid.

  logic [1:0] last_pick;
  logic [1:0] sel_idx;
  logic [1:0] idx;
  logic [3:0] starv_set;
  logic [3:0] cand;
  logic [3:0] sel_oh;
  logic       go;
  logic       ovr;
  logic       found;
  logic       unused_scan;

  assign so          = 1'b0;
  assign unused_scan = se ^ si;

  assign go        = ~swl_stall & (|thr_rdy);
  assign starv_set = thr_rdy & starv_limit;
  assign ovr       = |starv_set;
  // Starving threads use the same rotation so several of them share fairly.
  assign cand      = ovr ? starv_set : thr_rdy;

  always_comb begin
    sel_oh  = 4'b0000;
    sel_idx = last_pick;
    idx     = 2'd0;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = last_pick + 2'(k + 1);
      if (!found && cand[idx]) begin
        sel_oh[idx] = 1'b1;
        sel_idx     = idx;
        found       = 1'b1;
      end
    end
  end

  // A counter runs only while its thread is ready and not picked.
  assign rst_ctr_l = {4{~reset}} & thr_rdy & ~({4{go}} & sel_oh);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_pick <= 2'd3;
      pick_oh   <= 4'b0000;
      pick_vld  <= 1'b0;
      pick_ovr  <= 1'b0;
    end else begin
      pick_oh  <= go ? sel_oh : 4'b0000;
      pick_vld <= go;
      pick_ovr <= go & ovr;
      if (go) begin
        last_pick <= sel_idx;
      end
    end
  end

  // Clear beats a coincident increment; the count saturates rather than wraps.
  always_ff @(posedge clk) begin
    if (reset || clr_ovr_cnt) begin
      ovr_cnt <= 8'd0;
    end else if (go && ovr && (ovr_cnt != 8'hFF)) begin
      ovr_cnt <= ovr_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sparc_ifu_starv_pick.sv
// Randomized and directed bench for sparc_ifu_starv_pick, checked against a
// pointer-and-scan reference model through an expected-response queue.
module tb_sparc_ifu_starv_pick;

  logic       clk = 1'b0;
  logic       reset;
  logic       se;
  logic       si;
  logic       so;
  logic [3:0] thr_rdy;
  logic       swl_stall;
  logic [3:0] starv_limit;
  logic       clr_ovr_cnt;
  logic [3:0] rst_ctr_l;
  logic [3:0] pick_oh;
  logic       pick_vld;
  logic       pick_ovr;
  logic [7:0] ovr_cnt;

  localparam int W = 14;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int m_ptr  = 3;
  int m_cnt  = 0;

  sparc_ifu_starv_pick dut (
    .clk         (clk),
    .reset       (reset),
    .se          (se),
    .si          (si),
    .so          (so),
    .thr_rdy     (thr_rdy),
    .swl_stall   (swl_stall),
    .starv_limit (starv_limit),
    .clr_ovr_cnt (clr_ovr_cnt),
    .rst_ctr_l   (rst_ctr_l),
    .pick_oh     (pick_oh),
    .pick_vld    (pick_vld),
    .pick_ovr    (pick_ovr),
    .ovr_cnt     (ovr_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // driver + reference model: one call per cycle
  task automatic step(input logic [3:0] rdy, input logic stall, input logic [3:0] lim,
                      input logic clr, input logic rst);
    logic [3:0] starving, pool, exp_rc, exp_oh;
    int  pick;
    bit  go, ovr;
    @(negedge clk);
    thr_rdy     = rdy;
    swl_stall   = stall;
    starv_limit = lim;
    clr_ovr_cnt = clr;
    reset       = rst;
    se          = 1'($urandom_range(0, 1));
    si          = 1'($urandom_range(0, 1));
    #1;
    if (rst) begin
      exp_rc = 4'b0000;
      m_ptr  = 3;
      m_cnt  = 0;
      exp_q.push_back('0);
    end else begin
      go       = !stall && (rdy != 0);
      starving = rdy & lim;
      ovr      = (starving != 0);
      pool     = ovr ? starving : rdy;
      pick     = -1;
      for (int k = 1; k <= 4; k++) begin
        if (pick < 0 && pool[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
      end
      exp_oh = 4'b0000;
      if (go) exp_oh[pick] = 1'b1;
      for (int i = 0; i < 4; i++) exp_rc[i] = rdy[i] && !(go && pick == i);
      if (clr) m_cnt = 0;
      else if (go && ovr && m_cnt < 255) m_cnt = m_cnt + 1;
      if (go) m_ptr = pick;
      exp_q.push_back({go, go && ovr, exp_oh, 8'(m_cnt)});
    end
    checks++;
    if (rst_ctr_l !== exp_rc) begin
      errors++;
      $display("FAIL rst_ctr_l t=%0t got=%b exp=%b (rdy=%b stall=%b rst=%b)",
               $time, rst_ctr_l, exp_rc, rdy, stall, rst);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {pick_vld, pick_ovr, pick_oh, ovr_cnt};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL pick t=%0t got vld=%b ovr=%b oh=%b cnt=%0d exp vld=%b ovr=%b oh=%b cnt=%0d",
                   $time, got[13], got[12], got[11:8], got[7:0], e[13], e[12], e[11:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; se = 1'b0; si = 1'b0; thr_rdy = '0; swl_stall = 1'b0;
    starv_limit = '0; clr_ovr_cnt = 1'b0;

    // plain rotation
    step(4'b0000, 0, 4'b0000, 0, 1);
    repeat (8) step(4'b1111, 0, 4'b0000, 0, 0);

    // two ready threads alternate
    step(4'b0000, 0, 4'b0000, 0, 1);
    repeat (6) step(4'b0101, 0, 4'b0000, 0, 0);

    // starvation override jumps the rotation, then rotation resumes
    step(4'b0000, 0, 4'b0000, 0, 1);
    step(4'b0001, 0, 4'b0000, 0, 0);
    step(4'b1111, 0, 4'b1000, 0, 0);
    step(4'b1111, 0, 4'b0000, 0, 0);

    // stall holds the pointer while ready threads keep counting
    step(4'b0011, 0, 4'b0000, 0, 0);
    repeat (3) step(4'b0011, 1, 4'b0000, 0, 0);
    repeat (2) step(4'b0011, 0, 4'b0000, 0, 0);

    // idle, limit on a non-ready thread, single ready thread
    step(4'b0000, 0, 4'b1111, 0, 0);
    repeat (3) step(4'b0001, 0, 4'b0010, 0, 0);

    // override counter saturation and clear-beats-increment
    step(4'b0000, 0, 4'b0000, 1, 0);
    repeat (260) step(4'b1111, 0, 4'b1111, 0, 0);
    step(4'b1111, 0, 4'b0110, 1, 0);
    step(4'b1111, 0, 4'b0110, 0, 0);

    // reset coincident with a pick request
    step(4'b1111, 0, 4'b0100, 0, 0);
    step(4'b1111, 0, 4'b0100, 0, 1);
    step(4'b0110, 0, 4'b0000, 0, 0);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
           ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 150) == 0));
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected picks never observed, exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
